// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target exposing an 8 x 8-bit register file
module i2c_slave_regs #(
  parameter logic [6:0] ADDRESS   = 7'h1A,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclIn,
  input  logic        sdaIn,
  output logic        sdaOut,
  output logic [63:0] regs,
  output logic        wrStrobe,
  output logic [2:0]  wrIndex,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, PTR, WDATA, TX, WAIT_STOP} state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [3:0] bit_cnt;
  logic       ack_slot;
  logic       rw;
  logic [7:0] shift;
  logic [2:0] ptr;

  logic       scl_rise, scl_fall, start, stop, active;
  logic [7:0] rx_byte, cur_reg;

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start    = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop     = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign active   = (state == ADDR) || (state == PTR) || (state == WDATA) || (state == TX);
  assign rx_byte  = {shift[6:0], sda_s2};
  assign cur_reg  = regs[{ptr, 3'b000} +: 8];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      sdaOut   <= 1'b1;
      busy     <= 1'b0;
      wrStrobe <= 1'b0;
      wrIndex  <= 3'd0;
      ptr      <= 3'd0;
      regs     <= {8{RESET_VAL}};
      bit_cnt  <= 4'd0;
      ack_slot <= 1'b0;
      rw       <= 1'b0;
      shift    <= 8'h00;
    end else begin
      scl_s1   <= sclIn;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= sdaIn;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      wrStrobe <= 1'b0;

      if (start) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        ack_slot <= 1'b0;
        sdaOut   <= 1'b1;
        busy     <= 1'b0;
      end else if (stop) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        ack_slot <= 1'b0;
        sdaOut   <= 1'b1;
        busy     <= 1'b0;
      end else if (scl_rise && active) begin
        if (bit_cnt < 4'd8) begin
          // The transmit shifter is advanced on SCL falls, not here
          if (state != TX) shift <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            case (state)
              ADDR: begin
                if (rx_byte[7:1] == ADDRESS) begin
                  rw   <= rx_byte[0];
                  busy <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
              PTR: ptr <= rx_byte[2:0];
              WDATA: begin
                regs[{ptr, 3'b000} +: 8] <= rx_byte;
                wrStrobe <= 1'b1;
                wrIndex  <= ptr;
                ptr      <= ptr + 3'd1;
              end
              default: ;
            endcase
          end
        end else if (ack_slot && state == TX) begin
          if (sda_s2) state <= WAIT_STOP;
          else        ptr   <= ptr + 3'd1;
        end
      end else if (scl_fall && active) begin
        if (ack_slot) begin
          ack_slot <= 1'b0;
          bit_cnt  <= 4'd0;
          sdaOut   <= 1'b1;
          case (state)
            ADDR: begin
              if (rw) begin
                state  <= TX;
                sdaOut <= cur_reg[7];
                shift  <= {cur_reg[6:0], 1'b0};
              end else begin
                state <= PTR;
              end
            end
            PTR: state <= WDATA;
            TX: begin
              sdaOut <= cur_reg[7];
              shift  <= {cur_reg[6:0], 1'b0};
            end
            default: ;
          endcase
        end else if (bit_cnt == 4'd8) begin
          // Ninth clock: we ACK received bytes, but release SDA for the master's ACK in TX
          ack_slot <= 1'b1;
          sdaOut   <= (state == TX);
        end else if (state == TX && bit_cnt != 4'd0) begin
          sdaOut <= shift[7];
          shift  <= {shift[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - randomized I2C master driving i2c_slave_regs against a register-file model
module tb_i2c_slave_regs;
  localparam logic [6:0] DEV = 7'h1A;
  localparam int Q = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sdaOut;
  logic [63:0] regs;
  logic        wrStrobe;
  logic [2:0]  wrIndex;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [8];
  int         m_ptr;
  logic [7:0] buf_b [16];
  int         obs_q[$];
  int         exp_q[$];
  int         low_cnt;
  int         busy_cnt;

  assign sda_bus = sda_m & sdaOut;

  i2c_slave_regs dut (
    .clock(clock), .reset(reset), .sclIn(scl), .sdaIn(sda_bus), .sdaOut(sdaOut),
    .regs(regs), .wrStrobe(wrStrobe), .wrIndex(wrIndex), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wrStrobe) obs_q.push_back(int'(wrIndex));
    if (!sdaOut) low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    ack = sda_bus; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl = 1'b1;   wait_q();
      d[i] = sda_bus; wait_q();
      scl = 1'b0;   wait_q();
    end
    send_bit(master_ack);
    sda_m = 1'b1;
  endtask

  // buf_b[0] is the pointer byte, buf_b[1..n-1] the data bytes
  task automatic do_write(input logic [6:0] a, input int n);
    logic ack;
    logic match;
    match = (a == DEV);
    obs_q.delete(); exp_q.delete();
    low_cnt = 0; busy_cnt = 0;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check("addr_ack", ack, match ? 1'b0 : 1'b1);
    for (int i = 0; i < n; i++) begin
      write_byte(buf_b[i], ack);
      check("byte_ack", ack, match ? 1'b0 : 1'b1);
      if (match) begin
        if (i == 0) m_ptr = int'(buf_b[0][2:0]);
        else begin
          m_regs[m_ptr] = buf_b[i];
          exp_q.push_back(m_ptr);
          m_ptr = (m_ptr + 1) % 8;
        end
      end
    end
    i2c_stop();
    check("strobe_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("wr_index", obs_q[i], exp_q[i]);
    check("regs_after_write", regs, model_regs());
    check("busy_after_stop", busy, 1'b0);
    if (!match) begin
      check("foreign_sda_low_cycles", low_cnt, 0);
      check("foreign_busy_cycles", busy_cnt, 0);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input logic set_ptr, input int p, input int n);
    logic ack;
    logic match;
    logic [7:0] d;
    match = (a == DEV);
    if (set_ptr) begin
      i2c_start();
      write_byte({a, 1'b0}, ack);
      check("rd_addr_w_ack", ack, match ? 1'b0 : 1'b1);
      write_byte(8'(p), ack);
      check("rd_ptr_ack", ack, match ? 1'b0 : 1'b1);
      if (match) m_ptr = p % 8;
    end
    i2c_start();
    write_byte({a, 1'b1}, ack);
    check("rd_addr_r_ack", ack, match ? 1'b0 : 1'b1);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        read_byte(d, (i == n - 1));
        check("read_data", d, m_regs[m_ptr]);
        if (i != n - 1) m_ptr = (m_ptr + 1) % 8;
      end
      check("released_after_nack", sdaOut, 1'b1);
    end
    i2c_stop();
    check("busy_after_read", busy, 1'b0);
  endtask

  initial begin
    logic ack;
    logic [7:0] b;
    int kind;
    int n;
    logic [6:0] a;

    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0;

    repeat (4) @(negedge clock);
    check("reset_sdaOut", sdaOut, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_wrStrobe", wrStrobe, 1'b0);
    check("reset_wrIndex", wrIndex, 3'd0);
    check("reset_regs", regs, 64'h0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Write 0xA5 to register 2
    buf_b[0] = 8'h02; buf_b[1] = 8'hA5;
    do_write(DEV, 2);
    check("reg2_a5", regs[23:16], 8'hA5);

    // Set pointer 2, repeated start, read two bytes
    do_read(DEV, 1'b1, 2, 2);

    // Foreign address must be ignored
    buf_b[0] = 8'h02; buf_b[1] = 8'hFF;
    do_write(7'h1B, 2);

    // Pointer wraps from 7 to 0
    buf_b[0] = 8'h07; buf_b[1] = 8'h11; buf_b[2] = 8'h22;
    do_write(DEV, 3);
    check("reg7_11", regs[63:56], 8'h11);
    check("reg0_22", regs[7:0], 8'h22);

    // STOP in the middle of a data byte
    i2c_start();
    write_byte(8'h34, ack);
    check("mid_addr_ack", ack, 1'b0);
    write_byte(8'h01, ack);
    check("mid_ptr_ack", ack, 1'b0);
    m_ptr = 1;
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    check("mid_no_strobe", obs_q.size(), 0);
    check("mid_regs", regs, model_regs());
    check("mid_busy", busy, 1'b0);
    check("mid_sdaOut", sdaOut, 1'b1);

    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          n = $urandom_range(2, 5);
          for (int i = 0; i < n; i++) buf_b[i] = 8'($urandom);
          do_write(DEV, n);
        end
        1: do_read(DEV, 1'b1, $urandom_range(0, 7), $urandom_range(1, 4));
        2: do_read(DEV, 1'b0, 0, $urandom_range(1, 3));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == DEV) a = 7'h1B;
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) buf_b[i] = 8'($urandom);
          do_write(a, n);
        end
      endcase
    end

    // Asynchronous reset while the address ACK is being driven
    i2c_start();
    b = 8'h34;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1;
    repeat (4) @(negedge clock);
    check("ack_driven_before_reset", sdaOut, 1'b0);
    #3 reset = 1'b0;
    #1;
    check("async_reset_sdaOut", sdaOut, 1'b1);
    check("async_reset_regs", regs, 64'h0);
    check("async_reset_ptr", dut.ptr, 3'd0);
    check("async_reset_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    i2c_stop();
    do_read(DEV, 1'b0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h1A, which is the 7-bit I2C target address.
REQ-002 SHALL have parameter RESET_VAL, default 8'h00, which is the reset value of every register.
REQ-003 SHALL have port clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port sclIn, input, 1 bit: raw I2C SCL pin level (asynchronous).
REQ-006 SHALL have port sdaIn, input, 1 bit: raw I2C SDA pin level (asynchronous).
REQ-007 SHALL have port sdaOut, output, 1 bit: open-drain control; 0 = drive SDA low, 1 = release.
REQ-008 SHALL have port regs, output, 64 bits: 8 x 8-bit register file, reg n at bits [8n+7:8n].
REQ-009 SHALL have port wrStrobe, output, 1 bit: one-cycle pulse per register written over I2C.
REQ-010 SHALL have port wrIndex, output, 3 bits: index of the register written; valid when wrStrobe=1.
REQ-011 SHALL have port busy, output, 1 bit: 1 while an addressed transaction is in progress.

Function
REQ-012 SHALL pass sclIn and sdaIn through 2-FF synchronizers, plus one history register each, for edge detection.
REQ-013 SHALL detect START when synchronized SDA falls while SCL=1, and STOP when SDA rises while SCL=1.
REQ-014 SHALL give START/STOP detection priority over data-bit handling in the same cycle; clock ≥ 16x SCL rate assumed, no clock stretching.
REQ-015 SHALL sample data on the synchronized SCL rising edge, and change sdaOut only on the cycle after a synchronized SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, PTR, WDATA, TX, WAIT_STOP; bit counter 0..8; 3-bit pointer ptr.
REQ-017 SHALL behave in IDLE as follows: sdaOut=1, busy=0; START -> ADDR with bit counter=0.
REQ-018 SHALL behave in ADDR as follows: shift 8 bits MSB first; byte[7:1]==ADDRESS -> ACK and latch R/W; mismatch -> WAIT_STOP without ACK.
REQ-019 SHALL perform ACK by driving sdaOut=0 from the SCL fall after bit 8 until the SCL fall after bit 9, then releasing.
REQ-020 SHALL go after address ACK to PTR if R/W=0, or to TX if R/W=1, loading regs[ptr] into the shift register; busy=1 from address match until STOP/START.
REQ-021 SHALL behave in PTR as follows: receive 8 bits, ptr <= byte[2:0] (bits 7:3 ignored), ACK, -> WDATA.
REQ-022 SHALL behave in WDATA as follows: on bit-8 SCL rise, regs[ptr] <= byte, wrStrobe=1 for one clock, wrIndex=ptr, ptr <= ptr+1 mod 8 (7 -> 0); ACK; stay WDATA.
REQ-023 SHALL behave in TX as follows: present the shift-register MSB first, one bit per SCL fall; release SDA for bit 9; sample master ACK on bit-9 SCL rise.
REQ-024 SHALL, in TX, on master ACK (0) set ptr <= ptr+1 mod 8 and load regs[new ptr]; on NACK (1) go to WAIT_STOP with SDA released.
REQ-025 SHALL behave in WAIT_STOP as follows: sdaOut=1, ignore bits; START -> ADDR, STOP -> IDLE.
REQ-026 SHALL, on START in any state (repeated start), go -> ADDR, bit counter=0, sdaOut=1, ptr retained.
REQ-027 SHALL, on STOP in any state, go -> IDLE, sdaOut=1; a partial byte is discarded with no register write.
REQ-028 SHALL retain ptr across transactions; regs change only via REQ-022.

Reset
REQ-029 SHALL, while reset=0, immediately set state=IDLE, sdaOut=1, busy=0, wrStrobe=0, wrIndex=0, ptr=0, every register=RESET_VAL, and synchronizer/history registers=1.
REQ-030 SHALL take effect in reset mid-transaction without waiting for clock; after reset deassertion, the first START is required before any response.

Verification
REQ-031 SHALL be verified by a bench for write: START, 0x34, 0x02, 0xA5, STOP -> three ACKs, regs[23:16]=0xA5, exactly one wrStrobe with wrIndex=2.
REQ-032 SHALL be verified by a bench for read: after REQ-031, START 0x34 0x02, Sr 0x35, read with ACK then NACK -> bytes 0xA5 then 0x00 (reg3), SDA released after NACK.
REQ-033 SHALL be verified by a bench for wrong address: START 0x36 0x02 0xFF STOP -> sdaOut=1 throughout, regs unchanged, busy=0.
REQ-034 SHALL be verified by a bench for pointer wrap: START 0x34 0x07 0x11 0x22 STOP -> reg7=0x11, reg0=0x22, wrIndex sequence 7 then 0.
REQ-035 SHALL be verified by a bench for STOP mid-byte: START 0x34 0x01, 4 data bits, STOP -> no wrStrobe, reg1 unchanged, state IDLE.
REQ-036 SHALL be verified by a bench for reset during ACK: reset=0 while sdaOut=0 -> sdaOut=1 the same instant, all regs=0x00, ptr=0.
